gate_truth_table_scanner: RTL and testbench
===========================================

Name: gate_truth_table_scanner

Overview:
Sequencer that drives the operand and function-select inputs of the programmable gate and captures its output.
- Steps through all 16 combinations of {f1, f0, a, b} in order.
- Waits a programmable settle time per vector, then samples y into a 16-bit truth-table register.
- Used as the self-test and characterisation stage wrapped around the gate; start/busy/done handshake to the controller.

Parameters:
SETTLE_CYCLES, 1, extra cycles each vector is held before y is sampled; legal range 0..255.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  scan request; accepted only while busy==0.
y  input  1  gate output under test.
a  output  1  gate operand A.
b  output  1  gate operand B.
f0  output  1  gate function select bit 0.
f1  output  1  gate function select bit 1.
busy  output  1  high while a scan is in progress.
done  output  1  one-cycle pulse when a scan completes.
table_out  output  16  captured truth table; bit i holds y for vector i.

Behaviour:
- Reset (rst_n low, asynchronous):
  - a, b, f0, f1, busy, done = 0; table_out = 16'h0000.
  - State IDLE; vector index = 0; settle counter = 0.
  - Reset asserted mid-scan aborts the scan immediately; no done pulse is produced.
- Vector encoding: index i[3:0] maps as b=i[0], a=i[1], f0=i[2], f1=i[3]. Index runs 0..15 ascending.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - Operands driven 0; busy=0.
  - When start==1 at a clock edge: table_out cleared to 0, index=0, counter=SETTLE_CYCLES, go to SETTLE.
- SETTLE:
  - busy=1; operands reflect the current index, registered outputs with no glitch between vectors.
  - Counter decrements each cycle while nonzero.
  - On the edge where counter==0: table_out[index] <= y.
    - If index==15, go to DONE.
    - Otherwise index+1, counter reloads to SETTLE_CYCLES.
  - Each vector occupies exactly SETTLE_CYCLES+1 cycles.
  - busy is high for exactly 16*(SETTLE_CYCLES+1) cycles.
- DONE:
  - Lasts one cycle: done=1, busy=0, operands 0; table_out holds the final value.
  - Next state is IDLE.
  - start==1 during DONE is accepted exactly as in IDLE (back-to-back scans, no dead cycle).
- start while busy==1 is ignored; no queuing.
- table_out is stable from DONE until the next accepted start. It is only written in SETTLE.
- Index increment never wraps inside a scan. Transition out of index 15 goes to DONE, not to 0.

Optional Feature:
Macro SCAN_CHECK_EN.
- With the macro defined, extra ports are present:
  - expected  input  16: golden truth table, registered when start is accepted.
  - mismatch  output  1: asserted together with done when table_out != registered expected; held until the next accepted start or reset.
  - err_idx  output  4: lowest index where table_out and expected differ; 0 when mismatch=0.
  - Reset values: mismatch=0, err_idx=0, expected register=0.
- Without the macro: these ports and their registers do not exist. Behaviour is otherwise identical.

Test Plan:
1. Bench gate model y=a&b, SETTLE_CYCLES=1, start pulse -> busy high 32 cycles, single done pulse, table_out=16'h8888.
2. Model y=a^b, SETTLE_CYCLES=0 -> busy high 16 cycles, table_out=16'h6666; monitor shows {f1,f0,a,b} stepping 0000..1111, one step per cycle.
3. start held high continuously, SETTLE_CYCLES=2 -> start ignored while busy; scans repeat with exactly 48 busy cycles then a 1-cycle done between them; table_out cleared at each restart.
4. rst_n pulled low at vector 7 mid-scan -> a/b/f0/f1/busy/done/table_out all 0 immediately (asynchronously), no done pulse; a new start after release gives a full correct scan.
5. SCAN_CHECK_EN defined, model y=a|b, expected=16'hEEEE -> mismatch=0, err_idx=0. Same model with expected=16'hEEEF -> mismatch=1 with done, err_idx=0.
6. Model y stuck 0, SETTLE_CYCLES=255 -> busy high 4096 cycles, table_out=16'h0000, counter reload correct at maximum value.

Source files
------------

// File: rtl/gate_truth_table_scanner_if.sv
// Handshake and gate-drive signals of the truth-table scanner.
// SCAN_CHECK_EN adds the golden-table compare signals.
interface gate_truth_table_scanner_if;
    logic        start;
    logic        y;
    logic        a;
    logic        b;
    logic        f0;
    logic        f1;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
`ifdef SCAN_CHECK_EN
    logic [15:0] expected;
    logic        mismatch;
    logic [3:0]  err_idx;

    modport slave (
        input  start, y, expected,
        output a, b, f0, f1, busy, done, table_out, mismatch, err_idx
    );
    modport master (
        output start, y, expected,
        input  a, b, f0, f1, busy, done, table_out, mismatch, err_idx
    );
`else
    modport slave (
        input  start, y,
        output a, b, f0, f1, busy, done, table_out
    );
    modport master (
        output start, y,
        input  a, b, f0, f1, busy, done, table_out
    );
`endif
endinterface

// File: rtl/gate_truth_table_scanner.sv
// Steps the gate through all 16 {f1,f0,a,b} vectors and captures y into a truth table.
// Optional golden-table compare enabled by SCAN_CHECK_EN.
module gate_truth_table_scanner #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    gate_truth_table_scanner_if.slave   bus_io
);

    typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

    localparam logic [7:0] SettleLd = 8'(SETTLE_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] table_q, table_d;

    // idx_q doubles as the operand register; it is forced to 0 outside a scan.
    assign bus_io.b         = idx_q[0];
    assign bus_io.a         = idx_q[1];
    assign bus_io.f0        = idx_q[2];
    assign bus_io.f1        = idx_q[3];
    assign bus_io.busy      = (state_q == StSettle);
    assign bus_io.done      = (state_q == StDone);
    assign bus_io.table_out = table_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus_io.start) begin
                    table_d = 16'h0000;
                    idx_d   = 4'd0;
                    cnt_d   = SettleLd;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    table_d[idx_q] = bus_io.y;
                    if (idx_q == 4'd15) begin
                        idx_d   = 4'd0;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        cnt_d = SettleLd;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 4'd0;
            cnt_q   <= 8'd0;
            table_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
        end
    end

`ifdef SCAN_CHECK_EN
    logic [15:0] exp_q, exp_d;
    logic        mism_q, mism_d;
    logic [3:0]  err_q, err_d;
    logic [15:0] diff;
    logic [3:0]  low;
    logic        accept;
    logic        scan_end;

    assign accept   = (state_q != StSettle) && bus_io.start;
    assign scan_end = (state_q == StSettle) && (cnt_q == 8'd0) && (idx_q == 4'd15);

    always_comb begin
        exp_d  = exp_q;
        mism_d = mism_q;
        err_d  = err_q;
        // Compare against the table including the final sample being written this edge.
        diff   = table_d ^ exp_q;
        low    = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (diff[i]) low = 4'(i);
        end
        if (accept) begin
            exp_d  = bus_io.expected;
            mism_d = 1'b0;
            err_d  = 4'd0;
        end else if (scan_end) begin
            mism_d = |diff;
            err_d  = low;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q  <= 16'h0000;
            mism_q <= 1'b0;
            err_q  <= 4'd0;
        end else begin
            exp_q  <= exp_d;
            mism_q <= mism_d;
            err_q  <= err_d;
        end
    end

    assign bus_io.mismatch = mism_q;
    assign bus_io.err_idx  = err_q;
`endif

endmodule

// File: tb/tb_gate_truth_table_scanner.sv
// Bench for gate_truth_table_scanner: four DUTs (settle 0/1/2/255) share a gate model y = tt[vector].
// Compare checks compile in when SCAN_CHECK_EN is defined.
module tb_gate_truth_table_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  sel;
    logic [15:0] tt;
    logic [15:0] exp_v;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    gate_truth_table_scanner_if if0 ();
    gate_truth_table_scanner_if if1 ();
    gate_truth_table_scanner_if if2 ();
    gate_truth_table_scanner_if if3 ();

    gate_truth_table_scanner #(.SETTLE_CYCLES(0))   u0 (.clk(clk), .rst_n(rst_n), .bus_io(if0));
    gate_truth_table_scanner #(.SETTLE_CYCLES(1))   u1 (.clk(clk), .rst_n(rst_n), .bus_io(if1));
    gate_truth_table_scanner #(.SETTLE_CYCLES(2))   u2 (.clk(clk), .rst_n(rst_n), .bus_io(if2));
    gate_truth_table_scanner #(.SETTLE_CYCLES(255)) u3 (.clk(clk), .rst_n(rst_n), .bus_io(if3));

    assign if0.start = start && (sel == 2'd0);
    assign if1.start = start && (sel == 2'd1);
    assign if2.start = start && (sel == 2'd2);
    assign if3.start = start && (sel == 2'd3);
    assign if0.y = tt[{if0.f1, if0.f0, if0.a, if0.b}];
    assign if1.y = tt[{if1.f1, if1.f0, if1.a, if1.b}];
    assign if2.y = tt[{if2.f1, if2.f0, if2.a, if2.b}];
    assign if3.y = tt[{if3.f1, if3.f0, if3.a, if3.b}];
`ifdef SCAN_CHECK_EN
    assign if0.expected = exp_v;
    assign if1.expected = exp_v;
    assign if2.expected = exp_v;
    assign if3.expected = exp_v;
`endif

    logic        busy_v, done_v, mism_v;
    logic [3:0]  vec_v, err_v;
    logic [15:0] tbl_v;

    always_comb begin
        busy_v = 1'b0; done_v = 1'b0; vec_v = 4'd0; tbl_v = 16'h0; mism_v = 1'b0; err_v = 4'd0;
        case (sel)
            2'd0: begin busy_v = if0.busy; done_v = if0.done; tbl_v = if0.table_out;
                        vec_v = {if0.f1, if0.f0, if0.a, if0.b}; end
            2'd1: begin busy_v = if1.busy; done_v = if1.done; tbl_v = if1.table_out;
                        vec_v = {if1.f1, if1.f0, if1.a, if1.b}; end
            2'd2: begin busy_v = if2.busy; done_v = if2.done; tbl_v = if2.table_out;
                        vec_v = {if2.f1, if2.f0, if2.a, if2.b}; end
            default: begin busy_v = if3.busy; done_v = if3.done; tbl_v = if3.table_out;
                        vec_v = {if3.f1, if3.f0, if3.a, if3.b}; end
        endcase
`ifdef SCAN_CHECK_EN
        case (sel)
            2'd0: begin mism_v = if0.mismatch; err_v = if0.err_idx; end
            2'd1: begin mism_v = if1.mismatch; err_v = if1.err_idx; end
            2'd2: begin mism_v = if2.mismatch; err_v = if2.err_idx; end
            default: begin mism_v = if3.mismatch; err_v = if3.err_idx; end
        endcase
`endif
    end

    // Truth table of a two-input gate over the 16 vectors (b=i[0], a=i[1]).
    function automatic logic [15:0] model_tt(input int kind);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            int av = (i / 2) % 2;
            int bv = i % 2;
            case (kind)
                0: r[i] = (av * bv) != 0;
                1: r[i] = (av + bv) == 1;
                2: r[i] = (av + bv) != 0;
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic int lowest_diff(input logic [15:0] x);
        for (int i = 0; i < 16; i++) if (x[i]) return i;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Counts busy cycles from the current negedge and checks the vector walk.
    task automatic watch_scan(input int s, input logic [15:0] t, input string tag);
        int cyc = 0;
        int bad = 0;
        while (busy_v && cyc < 16 * (s + 1) + 8) begin
            if (vec_v !== 4'(cyc / (s + 1))) bad++;
            if (done_v) bad++;
            cyc++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, cyc, 16 * (s + 1));
        check({tag, "_vec_seq"}, bad, 0);
        check({tag, "_done"}, done_v, 1);
        check({tag, "_table"}, tbl_v, t);
        check({tag, "_ops_zero"}, {busy_v, vec_v}, 0);
`ifdef SCAN_CHECK_EN
        check({tag, "_mismatch"}, mism_v, (t != exp_v));
        check({tag, "_err_idx"}, err_v, (t != exp_v) ? lowest_diff(t ^ exp_v) : 0);
`endif
    endtask

    task automatic run_scan(input int d, input int s, input logic [15:0] t,
                            input logic [15:0] e, input string tag);
        sel = 2'(d); tt = t; exp_v = e;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        watch_scan(s, t, tag);
        @(negedge clk);
        check({tag, "_post_idle"}, {busy_v, done_v}, 0);
        check({tag, "_table_hold"}, tbl_v, t);
`ifdef SCAN_CHECK_EN
        check({tag, "_mism_hold"}, mism_v, (t != exp_v));
`endif
    endtask

    initial begin
        int wait_cyc;
        logic [15:0] r;
        rst_n = 1'b0; start = 1'b0; sel = 2'd0; tt = 16'h0; exp_v = 16'h0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            sel = 2'(d); #1;
            check("reset_state", {busy_v, done_v, vec_v, tbl_v, mism_v, err_v}, 0);
        end
        @(negedge clk); rst_n = 1'b1;

        // AND gate, settle 1.
        check("and_tt_const", model_tt(0), 16'h8888);
        run_scan(1, 1, model_tt(0), model_tt(0), "and_s1");
        // XOR gate, settle 0.
        check("xor_tt_const", model_tt(1), 16'h6666);
        run_scan(0, 0, model_tt(1), model_tt(1), "xor_s0");

        // Random gate functions.
        for (int k = 0; k < 4; k++) begin
            r = 16'($urandom);
            run_scan(k % 2, k % 2, r, r, "rand");
        end

        // start held high on settle-2 DUT: back-to-back scans, cleared table each restart.
        sel = 2'd2; tt = 16'($urandom); exp_v = tt;
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            watch_scan(2, tt, "held");
            @(negedge clk);
            check("held_restart_busy", {busy_v, done_v}, 2'b10);
            check("held_table_clear", tbl_v, 0);
            tt = 16'($urandom); exp_v = tt;
        end
        start = 1'b0;
        watch_scan(2, tt, "held_last");
        @(negedge clk);
        check("held_idle", busy_v, 0);

        // Asynchronous reset at vector 7.
        sel = 2'd1; tt = 16'($urandom); exp_v = tt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_cyc = 0;
        while (vec_v != 4'd7 && wait_cyc < 64) begin
            wait_cyc++;
            @(negedge clk);
        end
        check("rst_reach_vec7", vec_v, 7);
        #2 rst_n = 1'b0;
        #1 check("rst_async", {busy_v, done_v, vec_v, tbl_v, mism_v, err_v}, 0);
        @(negedge clk);
        check("rst_no_done", {busy_v, done_v}, 0);
        rst_n = 1'b1;
        run_scan(1, 1, tt, tt, "after_rst");

`ifdef SCAN_CHECK_EN
        run_scan(1, 1, model_tt(2), 16'hEEEE, "or_match");
        run_scan(1, 1, model_tt(2), 16'hEEEF, "or_miss");
        r = 16'($urandom);
        run_scan(0, 0, r, r ^ (16'h1 << $urandom_range(15, 0)), "rand_miss");
`endif

        // Stuck-0 gate at maximum settle.
        run_scan(3, 255, model_tt(3), model_tt(3), "stuck_s255");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
